// File: rtl/mem_stage_dm.sv
// -----------------------------------------------------------------------------
// mem_stage_dm
//
// Data-memory responder sitting at the far end of the EX/MEM interface. It
// takes the MEM-stage access controls, performs word/half/byte stores into a
// word-organised RAM with byte lanes, and returns extended load data, the PC
// and an alignment/range status to the WB stage through a MEM/WB register.
//
// Parameters
//   ADDR_W   word-address width; the RAM holds 2**ADDR_W 32-bit words
//   BASE     byte address of RAM word 0 (must be word aligned)
//
// Ports
//   clk      pipeline clock, rising edge
//   reset    asynchronous active-low reset
//   M_PC     PC of the instruction in MEM
//   M_AO     byte address (ALU output)
//   M_RD2    store data; low byte/half used for sb/sh
//   s_w/s_h/s_b  store word/half/byte
//   l_w/l_h/l_b  load word/half/byte
//   ext      sign-extend (1) or zero-extend (0) half/byte loads
//   W_PC     registered M_PC
//   W_DR     registered, extended load data
//   W_ld     registered "a load completed" flag
//   W_err    registered alignment/range error flag
//   wr_en    registered: a RAM write took effect (trace)
//   wr_addr  registered word-aligned byte address of that write
//   wr_data  registered full post-merge word written
// -----------------------------------------------------------------------------
module mem_stage_dm #(
   parameter int          ADDR_W = 12,
   parameter logic [31:0] BASE   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] M_PC,
   input  logic [31:0] M_AO,
   input  logic [31:0] M_RD2,
   input  logic        s_w,
   input  logic        s_h,
   input  logic        s_b,
   input  logic        l_w,
   input  logic        l_h,
   input  logic        l_b,
   input  logic        ext,
   output logic [31:0] W_PC,
   output logic [31:0] W_DR,
   output logic        W_ld,
   output logic        W_err,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [31:0] mem [DEPTH];

   // Address decode. The subtraction is done on word addresses only; BASE is
   // word aligned, so this equals (M_AO-BASE)>>2 and leaves no unused bits.
   logic [29:0]       off_word;
   logic [ADDR_W-1:0] idx;
   logic [1:0]        lane;
   logic              in_range;

   assign off_word = M_AO[31:2] - BASE[31:2];
   assign idx      = off_word[ADDR_W-1:0];
   assign lane     = M_AO[1:0];
   assign in_range = (off_word[29:ADDR_W] == '0);

   // Effective operation after resolving illegal control combinations:
   // stores win over loads, and within each group the wider access wins.
   logic op_sw, op_sh, op_sb, op_lw, op_lh, op_lb;
   logic is_store, is_load, err;

   always_comb begin
      op_sw    = s_w;
      op_sh    = s_h & ~s_w;
      op_sb    = s_b & ~s_w & ~s_h;
      is_store = s_w | s_h | s_b;
      op_lw    = ~is_store & l_w;
      op_lh    = ~is_store & ~l_w & l_h;
      op_lb    = ~is_store & ~l_w & ~l_h & l_b;
      is_load  = op_lw | op_lh | op_lb;
      err      = 1'b0;
      if (is_store | is_load) begin
         if (!in_range)                         err = 1'b1;
         if ((op_sw | op_lw) && (lane != 2'd0)) err = 1'b1;
         if ((op_sh | op_lh) && lane[0])        err = 1'b1;
      end
   end

   // Store path: byte enables, lane-replicated data and read-modify merge.
   logic [31:0] rd_word;
   logic [3:0]  be;
   logic [31:0] wr_rep;
   logic [31:0] merged;
   logic        do_write;

   assign rd_word  = mem[idx];
   assign do_write = is_store & ~err;

   always_comb begin
      be     = 4'b0000;
      wr_rep = M_RD2;
      if (op_sw) begin
         be     = 4'b1111;
         wr_rep = M_RD2;
      end else if (op_sh) begin
         be     = lane[1] ? 4'b1100 : 4'b0011;
         wr_rep = {2{M_RD2[15:0]}};
      end else if (op_sb) begin
         be     = 4'b0001 << lane;
         wr_rep = {4{M_RD2[7:0]}};
      end
      for (int i = 0; i < 4; i++) begin
         merged[i*8 +: 8] = be[i] ? wr_rep[i*8 +: 8] : rd_word[i*8 +: 8];
      end
   end

   // Load path: select and extend from the current (pre-edge) RAM word.
   logic [15:0] ld_half;
   logic [7:0]  ld_byte;
   logic [31:0] ld_val;

   always_comb begin
      ld_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
      ld_byte = rd_word[{lane, 3'b000} +: 8];
      ld_val  = 32'h0;
      if (op_lw) begin
         ld_val = rd_word;
      end else if (op_lh) begin
         ld_val = {{16{ld_half[15] & ext}}, ld_half};
      end else if (op_lb) begin
         ld_val = {{24{ld_byte[7] & ext}}, ld_byte};
      end
   end

   // RAM array is never reset. The reset check keeps a store whose edge
   // coincides with an asserted reset from committing.
   always_ff @(posedge clk) begin
      if (reset && do_write) begin
         mem[idx] <= merged;
      end
   end

   // MEM/WB register and write-trace register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         W_PC    <= 32'h0;
         W_DR    <= 32'h0;
         W_ld    <= 1'b0;
         W_err   <= 1'b0;
         wr_en   <= 1'b0;
         wr_addr <= 32'h0;
         wr_data <= 32'h0;
      end else begin
         W_PC  <= M_PC;
         W_DR  <= (is_load && !err) ? ld_val : 32'h0;
         W_ld  <= is_load & ~err;
         W_err <= err;
         wr_en <= do_write;
         // Trace address/data hold their last value between writes.
         if (do_write) begin
            wr_addr <= {M_AO[31:2], 2'b00};
            wr_data <= merged;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage_dm.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_dm
//
// Self-checking bench for mem_stage_dm. A byte-addressed reference memory
// predicts every MEM/WB and write-trace output one cycle after each access.
// -----------------------------------------------------------------------------
module tb_mem_stage_dm;

   logic        clk;
   logic        reset;
   logic [31:0] M_PC, M_AO, M_RD2;
   logic        s_w, s_h, s_b, l_w, l_h, l_b, ext;
   logic [31:0] W_PC, W_DR, wr_addr, wr_data;
   logic        W_ld, W_err, wr_en;

   int errors = 0;
   int checks = 0;

   // Byte-addressed reference RAM (BASE = 0, 4096 words).
   localparam int NBYTES = 16384;
   logic [7:0] bm [NBYTES];

   logic [31:0] exp_pc, exp_dr, exp_waddr, exp_wdata;
   logic        exp_ld, exp_err, exp_wen;

   mem_stage_dm #(.ADDR_W(12), .BASE(32'h0)) dut (
      .clk     (clk),
      .reset   (reset),
      .M_PC    (M_PC),
      .M_AO    (M_AO),
      .M_RD2   (M_RD2),
      .s_w     (s_w),
      .s_h     (s_h),
      .s_b     (s_b),
      .l_w     (l_w),
      .l_h     (l_h),
      .l_b     (l_b),
      .ext     (ext),
      .W_PC    (W_PC),
      .W_DR    (W_DR),
      .W_ld    (W_ld),
      .W_err   (W_err),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".W_PC"},    W_PC,          exp_pc);
      check({tag, ".W_DR"},    W_DR,          exp_dr);
      check({tag, ".W_ld"},    {31'h0, W_ld},  {31'h0, exp_ld});
      check({tag, ".W_err"},   {31'h0, W_err}, {31'h0, exp_err});
      check({tag, ".wr_en"},   {31'h0, wr_en}, {31'h0, exp_wen});
      check({tag, ".wr_addr"}, wr_addr,       exp_waddr);
      check({tag, ".wr_data"}, wr_data,       exp_wdata);
   endtask

   function automatic logic [31:0] model_word(input logic [31:0] a);
      logic [31:0] w;
      int base;
      base = int'(a & 32'hFFFF_FFFC);
      w = {bm[base+3], bm[base+2], bm[base+1], bm[base]};
      return w;
   endfunction

   // ctl = {s_w, s_h, s_b, l_w, l_h, l_b, ext}
   task automatic do_op(input string tag, input logic [31:0] pc, input logic [31:0] addr,
                        input logic [31:0] data, input logic [6:0] ctl);
      logic st, ld, bad;
      int size;
      logic [31:0] val;
      st   = ctl[6] | ctl[5] | ctl[4];
      ld   = !st && (ctl[3] | ctl[2] | ctl[1]);
      size = ctl[6] ? 4 : ctl[5] ? 2 : ctl[4] ? 1 :
             !st && ctl[3] ? 4 : !st && ctl[2] ? 2 : !st && ctl[1] ? 1 : 0;
      bad  = (size != 0) && ((addr >= 32'h4000) || ((addr % size) != 0));
      exp_pc  = pc;
      exp_dr  = 32'h0;
      exp_ld  = 1'b0;
      exp_err = bad;
      exp_wen = 1'b0;
      if (ld && !bad) begin
         val = 32'h0;
         for (int b = 0; b < size; b++) val = val | (32'(bm[int'(addr) + b]) << (8 * b));
         if (ctl[0] && size < 4 && val[8*size-1]) val = val | ~((32'h1 << (8 * size)) - 1);
         exp_dr = val;
         exp_ld = 1'b1;
      end
      if (st && !bad) begin
         for (int b = 0; b < size; b++) bm[int'(addr) + b] = data[8*b +: 8];
         exp_wen   = 1'b1;
         exp_waddr = addr & 32'hFFFF_FFFC;
         exp_wdata = model_word(addr);
      end
      M_PC  = pc;
      M_AO  = addr;
      M_RD2 = data;
      {s_w, s_h, s_b, l_w, l_h, l_b, ext} = ctl;
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   localparam logic [6:0] C_NONE = 7'b000_000_0;
   localparam logic [6:0] C_SW   = 7'b100_000_0;
   localparam logic [6:0] C_SH   = 7'b010_000_0;
   localparam logic [6:0] C_SB   = 7'b001_000_0;
   localparam logic [6:0] C_LW   = 7'b000_100_0;
   localparam logic [6:0] C_LH   = 7'b000_010_0;
   localparam logic [6:0] C_LB   = 7'b000_001_0;

   initial begin
      logic [6:0]  ctl;
      logic [31:0] addr;
      for (int i = 0; i < NBYTES; i++) bm[i] = 8'h00;
      reset = 1'b0;
      M_PC = 0; M_AO = 0; M_RD2 = 0;
      {s_w, s_h, s_b, l_w, l_h, l_b, ext} = C_NONE;
      exp_pc = 0; exp_dr = 0; exp_ld = 0; exp_err = 0;
      exp_wen = 0; exp_waddr = 0; exp_wdata = 0;
      @(posedge clk);
      #1;
      check_all("reset");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Give the words used below a known value.
      for (int w = 0; w < 8; w++) do_op("init", 32'h100 + 32'(w), 32'(w * 4), 32'h0, C_SW);

      // Directed scenarios.
      do_op("sw10", 32'h200, 32'h10, 32'hDEADBEEF, C_SW);
      check("tp_sw_data", wr_data, 32'hDEADBEEF);
      do_op("sb11", 32'h204, 32'h11, 32'h000000AA, C_SB);
      check("tp_sb_data", wr_data, 32'hDEADAAEF);
      do_op("lb11", 32'h208, 32'h11, 32'h0, C_LB | 7'b1);
      check("tp_lb", W_DR, 32'hFFFFFFAA);
      do_op("lbu11", 32'h20C, 32'h11, 32'h0, C_LB);
      check("tp_lbu", W_DR, 32'h000000AA);
      do_op("sh12", 32'h210, 32'h12, 32'h00001234, C_SH);
      do_op("lh12", 32'h214, 32'h12, 32'h0, C_LH | 7'b1);
      check("tp_lh", W_DR, 32'h00001234);
      do_op("lw10", 32'h218, 32'h10, 32'h0, C_LW);
      check("tp_lw", W_DR, 32'h1234AAEF);
      do_op("lw13", 32'h21C, 32'h13, 32'h0, C_LW);
      check("tp_lw_misal", {31'h0, W_err}, 32'h1);
      do_op("sh11", 32'h220, 32'h11, 32'hFFFF5555, C_SH);
      check("tp_sh_misal", {31'h0, wr_en}, 32'h0);
      do_op("lw10b", 32'h224, 32'h10, 32'h0, C_LW);
      check("tp_lw_keep", W_DR, 32'h1234AAEF);
      do_op("oor_lw", 32'h228, 32'h4000, 32'h0, C_LW);
      do_op("oor_sw", 32'h22C, 32'hFFFFFFFC, 32'h12345678, C_SW);
      do_op("none", 32'h230, 32'h10, 32'h0, C_NONE);

      // Reset pulse between edges with W_DR nonzero; a store is held across
      // an edge while reset is low and must not commit.
      do_op("lw10c", 32'h234, 32'h10, 32'h0, C_LW);
      #3;
      reset = 1'b0;
      M_AO = 32'h10; M_RD2 = 32'hFFFFFFFF;
      {s_w, s_h, s_b, l_w, l_h, l_b, ext} = C_SW;
      exp_pc = 0; exp_dr = 0; exp_ld = 0; exp_err = 0;
      exp_wen = 0; exp_waddr = 0; exp_wdata = 0;
      #1;
      check_all("rst_async");
      @(posedge clk);
      #1;
      check_all("rst_hold");
      #2;
      reset = 1'b1;
      do_op("lw_after_rst", 32'h238, 32'h10, 32'h0, C_LW);
      check("tp_rst_keep", W_DR, 32'h1234AAEF);

      // Randomized traffic over 8 words, with occasional out-of-range and
      // illegal control combinations.
      for (int n = 0; n < 400; n++) begin
         addr = 32'($urandom_range(0, 31));
         if ($urandom_range(0, 15) == 0) addr = 32'h4000 + 32'($urandom_range(0, 255));
         case ($urandom_range(0, 7))
            0: ctl = C_NONE;
            1: ctl = C_SW;
            2: ctl = C_SH;
            3: ctl = C_SB;
            4: ctl = C_LW;
            5: ctl = C_LH;
            6: ctl = C_LB;
            default: begin
               ctl = {3'($urandom_range(0, 7)), 4'b0};
               case ($urandom_range(0, 3))
                  0: ctl[3] = 1'b1;
                  1: ctl[2] = 1'b1;
                  2: ctl[1] = 1'b1;
                  default: ;
               endcase
            end
         endcase
         ctl[0] = 1'($urandom_range(0, 1));
         do_op("rand", $urandom, addr, $urandom, ctl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
